// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame sequencer (uart_frame_ctrl).
package uart_frame_pkg;

  localparam logic [7:0] CMD_WR_DEFAULT = 8'h57;
  localparam logic [7:0] CMD_RD_DEFAULT = 8'h52;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CMD  = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_UND  = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_H   = 3'd1,
    LEN_L   = 3'd2,
    WR      = 3'd3,
    RD_REQ  = 3'd4,
    RD_LOAD = 3'd5,
    RD_WAIT = 3'd6,
    DONE    = 3'd7
  } ufc_state_e;

endpackage

// File: rtl/uart_frame_ctrl_timeout.sv
// Inter-byte timeout counter for uart_frame_ctrl; compiled only when UFC_TIMEOUT_EN is defined.
`ifdef UFC_TIMEOUT_EN
module ufc_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] cyc_q;
  logic [CW-1:0] cyc_d;

  always_comb begin
    cyc_d = cyc_q + CW'(1);
    if (!run || clr) cyc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  // An event in the expiry cycle wins, so a byte arriving just in time is kept.
  assign expired = run && !clr && (cyc_q == CW'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/uart_frame_ctrl.sv
// Frame sequencer: parses cmd/len_hi/len_lo then moves payload between UART and FIFO.
// Optional inter-byte timeout is enabled with the UFC_TIMEOUT_EN macro.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
`ifdef UFC_TIMEOUT_EN
  parameter int         TIMEOUT_CYC = 50000,
`endif
  parameter int         LEN_W  = 16,
  parameter logic [7:0] CMD_WR = CMD_WR_DEFAULT,
  parameter logic [7:0] CMD_RD = CMD_RD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rok,
  input  logic [7:0]       rx_data,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             fifo_wr,
  output logic [7:0]       fifo_wdata,
  output logic             fifo_rd,
  input  logic [7:0]       fifo_rdata,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  output logic [7:0]       cmd,
  output logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             frame_done,
  output logic [1:0]       err_code
);

  ufc_state_e       state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic             fifo_wr_q, fifo_wr_d;
  logic [7:0]       fifo_wdata_q, fifo_wdata_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             frame_done_q, frame_done_d;

  logic [LEN_W-1:0] len_lo;
  logic [LEN_W-1:0] cnt_inc;
  logic             cmd_bad;
  logic             to_expired;

  assign len_lo  = {frame_len_q[LEN_W-1:8], rx_data};
  assign cnt_inc = cnt_q + LEN_W'(1);
  assign cmd_bad = (cmd_q != CMD_WR) && (cmd_q != CMD_RD);

`ifdef UFC_TIMEOUT_EN
  logic to_run;
  logic to_clr;

  assign to_run = (state_q == LEN_H) || (state_q == LEN_L) ||
                  (state_q == WR)    || (state_q == RD_WAIT);
  assign to_clr = (state_q == RD_WAIT) ? tx_done : rok;

  ufc_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (to_run),
    .clr     (to_clr),
    .expired (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    frame_len_d  = frame_len_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fifo_wr_d    = 1'b0;
    fifo_wdata_d = fifo_wdata_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;

    case (state_q)
      IDLE: if (rok) begin
        cmd_d   = rx_data;
        err_d   = ERR_NONE;
        state_d = LEN_H;
      end
      LEN_H: if (rok) begin
        frame_len_d[LEN_W-1:8] = rx_data;
        state_d                = LEN_L;
      end
      LEN_L: if (rok) begin
        frame_len_d = len_lo;
        cnt_d       = '0;
        if (cmd_bad) err_d = ERR_CMD;
        if (cmd_bad || (len_lo == '0)) state_d = DONE;
        else if (cmd_q == CMD_WR)      state_d = WR;
        else                           state_d = RD_REQ;
      end
      // A byte that meets a full FIFO is still counted so the frame stays aligned.
      WR: if (rok) begin
        fifo_wdata_d = rx_data;
        if (fifo_full) err_d     = ERR_OVF;
        else           fifo_wr_d = 1'b1;
        cnt_d = cnt_inc;
        if (cnt_inc == frame_len_q) state_d = DONE;
      end
      RD_REQ: begin
        if (fifo_empty) begin
          err_d   = ERR_UND;
          state_d = DONE;
        end else begin
          state_d = RD_LOAD;
        end
      end
      RD_LOAD: begin
        tx_data_d  = fifo_rdata;
        tx_start_d = 1'b1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: if (tx_done) begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == frame_len_q) ? DONE : RD_REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (to_expired) begin
      err_d   = ERR_UND;
      state_d = DONE;
    end

    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      frame_len_q  <= '0;
      cnt_q        <= '0;
      err_q        <= ERR_NONE;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      frame_len_q  <= frame_len_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_wdata_q <= fifo_wdata_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Read strobe is issued in RD_REQ itself so fifo_rdata is valid during RD_LOAD.
  assign fifo_rd    = (state_q == RD_REQ) && !fifo_empty;
  assign fifo_wr    = fifo_wr_q;
  assign fifo_wdata = fifo_wdata_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign cmd        = cmd_q;
  assign frame_len  = frame_len_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign err_code   = err_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed frames, random frames and reset checks.
module tb_uart_frame_ctrl;
  import uart_frame_pkg::*;

  localparam int TO_CYC = 50000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rok = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rdata = '0;
  logic        tx_done = 1'b0;
  logic        fifo_wr, fifo_rd, tx_start, busy, frame_done;
  logic [7:0]  fifo_wdata, tx_data, cmd;
  logic [15:0] frame_len;
  logic [1:0]  err_code;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] wr_obs[$];
  logic [7:0] tx_obs[$];
  logic [7:0] pay_q[$];
  bit         full_q[$];
  logic [7:0] rd_pre[$];

  uart_frame_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rok        (rok),
    .rx_data    (rx_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .fifo_rd    (fifo_rd),
    .fifo_rdata (fifo_rdata),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .cmd        (cmd),
    .frame_len  (frame_len),
    .busy       (busy),
    .frame_done (frame_done),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (fifo_rd && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (fifo_wr) wr_obs.push_back(fifo_wdata);
    if (tx_start) tx_obs.push_back(tx_data);
    if (frame_done) done_cnt++;
    if (fifo_wr || fifo_rd) chk("wr_rd_exclusive", {31'd0, fifo_wr & fifo_rd}, 32'd0);
  end

  // Transmitter model: finishes each byte after a short random delay.
  always begin
    @(negedge clk);
    if (tx_start) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic full);
    @(negedge clk);
    rx_data   = b;
    rok       = 1'b1;
    fifo_full = full;
    @(negedge clk);
    rok       = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int start, input string tag);
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk(tag, done_cnt - start, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_a"}, {8'd0, fifo_wdata, tx_data, cmd}, 32'd0);
    chk({tag, "_b"}, {9'd0, frame_len, fifo_wr, fifo_rd, tx_start, busy, frame_done, err_code}, 32'd0);
    chk({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  // Write frame from pay_q/full_q: expected writes are the bytes that met a non-full FIFO.
  task automatic do_wr_frame(input string tag);
    logic [7:0] exp_q[$];
    logic [1:0] exp_err;
    int len, start;
    len = pay_q.size();
    start = done_cnt;
    exp_err = ERR_NONE;
    #1;
    wr_obs.delete();
    send_byte(8'h57, 1'b0);
    send_byte(8'(len >> 8), 1'b0);
    send_byte(8'(len), 1'b0);
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(pay_q[i], full_q[i]);
      chk({tag, "_wr_strobe"}, {31'd0, fifo_wr}, {31'd0, !full_q[i]});
      if (full_q[i]) exp_err = ERR_OVF;
      else begin
        exp_q.push_back(pay_q[i]);
        chk({tag, "_wr_data"}, {24'd0, fifo_wdata}, {24'd0, pay_q[i]});
      end
    end
    wait_done(20, start, {tag, "_done"});
    chk({tag, "_err"}, {30'd0, err_code}, {30'd0, exp_err});
    chk({tag, "_len"}, {16'd0, frame_len}, 32'(len));
    chk({tag, "_cmd"}, {24'd0, cmd}, 32'h57);
    chk({tag, "_wr_count"}, wr_obs.size(), exp_q.size());
    if (wr_obs.size() == exp_q.size())
      foreach (exp_q[i]) chk({tag, "_wr_seq"}, {24'd0, wr_obs[i]}, {24'd0, exp_q[i]});
  endtask

  // Read frame: transmits min(len, stored) bytes in FIFO order; short FIFO is an underrun.
  task automatic do_rd_frame(input int len, input string tag);
    int n, start;
    logic [1:0] exp_err;
    start = done_cnt;
    n = (len < rd_pre.size()) ? len : rd_pre.size();
    exp_err = (rd_pre.size() < len) ? ERR_UND : ERR_NONE;
    @(negedge clk);
    tx_obs.delete();
    fifo_q = rd_pre;
    send_byte(8'h52, 1'b0);
    send_byte(8'(len >> 8), 1'b0);
    send_byte(8'(len), 1'b0);
    wait_done(40 * len + 40, start, {tag, "_done"});
    chk({tag, "_err"}, {30'd0, err_code}, {30'd0, exp_err});
    chk({tag, "_len"}, {16'd0, frame_len}, 32'(len));
    chk({tag, "_tx_count"}, tx_obs.size(), 32'(n));
    if (tx_obs.size() == n)
      for (int i = 0; i < n; i++) chk({tag, "_tx_seq"}, {24'd0, tx_obs[i]}, {24'd0, rd_pre[i]});
    chk({tag, "_fifo_left"}, fifo_q.size(), 32'(rd_pre.size() - n));
  endtask

  initial begin
    int start, len, pre;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed write AA,BB,CC
    pay_q = '{8'hAA, 8'hBB, 8'hCC};
    full_q = '{0, 0, 0};
    do_wr_frame("wr_dir");

    // Directed read of 11,22
    rd_pre = '{8'h11, 8'h22};
    do_rd_frame(2, "rd_dir");

    // Bad command, then a new cmd byte clears the error
    start = done_cnt;
    wr_obs.delete();
    send_byte(8'h33, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    chk("badcmd_done_pulse", {31'd0, frame_done}, 32'd1);
    chk("badcmd_err", {30'd0, err_code}, 32'(ERR_CMD));
    @(negedge clk);
    chk("badcmd_done_single", {31'd0, frame_done}, 32'd0);
    chk("badcmd_idle", {31'd0, busy}, 32'd0);
    send_byte(8'h57, 1'b0);
    chk("newcmd_err_clear", {30'd0, err_code}, 32'(ERR_NONE));
    chk("newcmd_cmd", {24'd0, cmd}, 32'h57);
    chk("newcmd_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("zero_len_done", {31'd0, frame_done}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("zero_len_no_wr", wr_obs.size(), 32'd0);
    chk("badcmd_done_count", done_cnt - start, 32'd2);

    // Overflow: FIFO full for every payload byte
    pay_q = '{8'h5A, 8'hA5};
    full_q = '{1, 1};
    do_wr_frame("ovf");

    // Underrun: one byte stored, three requested
    rd_pre = '{8'h3C};
    do_rd_frame(3, "und");

    // Reset in the middle of a write frame
    pay_q.delete();
    send_byte(8'h57, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'hAA, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Random frames against the reference rules
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        len = $urandom_range(0, 6);
        pay_q.delete();
        full_q.delete();
        for (int i = 0; i < len; i++) begin
          pay_q.push_back(8'($urandom));
          full_q.push_back($urandom_range(0, 3) == 0);
        end
        do_wr_frame("rnd_wr");
      end else begin
        len = $urandom_range(0, 5);
        pre = $urandom_range(0, 5);
        rd_pre.delete();
        for (int i = 0; i < pre; i++) rd_pre.push_back(8'($urandom));
        do_rd_frame(len, "rnd_rd");
      end
    end

`ifdef UFC_TIMEOUT_EN
    // Stall in LEN_L until the inter-byte timeout fires
    start = done_cnt;
    send_byte(8'h57, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_done(TO_CYC + 20, start, "timeout_done");
    chk("timeout_err", {30'd0, err_code}, 32'(ERR_UND));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
